// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide engine.
// Holds the select/op encodings, the sequencer state type and small
// decode helpers used by muldiv_sequencer.
//
// Op encodings (op_i):
//   multiply (sel=0): 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   divide   (sel=1): 00 DIV, 01 DIVU, 10 REM,    11 REMU
package muldiv_sequencer_pkg;

  localparam logic       SEL_DIV   = 1'b1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  localparam logic [1:0] OP_DIVU   = 2'b01;
  localparam logic [1:0] OP_REM    = 2'b10;
  localparam logic [1:0] OP_REMU   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Whether rs1 is interpreted as a signed value for this op.
  // MUL only needs the low word, which is identical signed or unsigned.
  function automatic logic rs1_is_signed(input logic sel, input logic [1:0] op);
    if (sel == SEL_DIV) return !((op == OP_DIVU) || (op == OP_REMU));
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // Whether rs2 is interpreted as a signed value (MULHSU keeps rs2 unsigned).
  function automatic logic rs2_is_signed(input logic sel, input logic [1:0] op);
    if (sel == SEL_DIV) return !((op == OP_DIVU) || (op == OP_REMU));
    return op == OP_MULH;
  endfunction

  function automatic logic is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// Single radix-2 iteration of the multiply/divide datapath (combinational).
// The working pair {acc, opnd} is either the partial product / multiplier
// (shift-add, shifting right) or the partial remainder / dividend-quotient
// (restoring divide, shifting left).
//
// Ports:
//   div       1     0 = shift-add multiply step, 1 = restoring divide step
//   acc       XLEN  upper half of the working pair
//   opnd      XLEN  lower half of the working pair
//   b         XLEN  multiplicand or divisor magnitude
//   acc_nxt   XLEN  updated upper half
//   opnd_nxt  XLEN  updated lower half
module muldiv_sequencer_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opnd,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] opnd_nxt
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] part;
  logic          fits;

  // The partial remainder can momentarily need XLEN+1 bits after the shift,
  // but whenever the subtraction succeeds the difference is below the
  // divisor, so only the low XLEN bits of the difference are kept.
  always_comb begin
    add_sum  = {1'b0, acc} + (opnd[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
    part     = {acc, opnd[XLEN-1]};
    fits     = part >= {1'b0, b};
    acc_nxt  = '0;
    opnd_nxt = '0;
    if (div) begin
      acc_nxt  = fits ? (part[XLEN-1:0] - b) : part[XLEN-1:0];
      opnd_nxt = {opnd[XLEN-2:0], fits};
    end else begin
      acc_nxt  = add_sum[XLEN:1];
      opnd_nxt = {add_sum[0], opnd[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine with its sequencing FSM, placed in
// EX next to the ALU. Holds the pipeline through stall_o until the result is
// ready, then presents it for the EX result mux.
//
// Optional feature: define MULDIV_RESULT_CACHE_EN to add a one-entry result
// cache that lets a repeated operation (e.g. REM after DIV on the same
// operands) complete in a single cycle.
//
// Ports:
//   clk_i     in   1     clock, rising edge
//   reset_i   in   1     asynchronous active-low reset
//   start_i   in   1     muldiv instruction in EX, held while stalled
//   sel_i     in   1     0 = multiply, 1 = divide
//   op_i      in   2     operation within the selected group
//   rs1_i     in   XLEN  operand A / dividend
//   rs2_i     in   XLEN  operand B / divisor
//   flush_i   in   1     kill the in-flight operation
//   stall_o   out  1     start_i && state != DONE
//   done_o    out  1     high for the single DONE cycle
//   result_o  out  XLEN  result, held until the next completion
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            sel_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   acc, opnd, b_reg, result_q;
  logic [XLEN-1:0]   acc_step, opnd_step;
  logic              sel_q, neg_main_q, neg_rem_q;
  logic [1:0]        op_q;

  logic              a_neg, b_neg, div_zero, div_ovf, special, hit;
  logic [XLEN-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [2*XLEN-1:0] special_word, hit_word, prod_abs, fix_word, done_word;
  logic              accept, load_result, done_sel;
  logic [1:0]        done_op;

  // Words are always {hi, lo}: the 64b product, or {rem, quot} for divides.
  function automatic logic [XLEN-1:0] pick_word(input logic sel, input logic [1:0] op,
                                                input logic [2*XLEN-1:0] word);
    if (sel == SEL_DIV) return is_rem(op) ? word[2*XLEN-1:XLEN] : word[XLEN-1:0];
    return (op == OP_MUL) ? word[XLEN-1:0] : word[2*XLEN-1:XLEN];
  endfunction

  muldiv_sequencer_step #(.XLEN(XLEN)) u_step (
    .div      (sel_q),
    .acc      (acc),
    .opnd     (opnd),
    .b        (b_reg),
    .acc_nxt  (acc_step),
    .opnd_nxt (opnd_step)
  );

  // Operand magnitudes and the two divide corner cases that bypass CALC.
  always_comb begin
    a_neg        = rs1_is_signed(sel_i, op_i) && rs1_i[XLEN-1];
    b_neg        = rs2_is_signed(sel_i, op_i) && rs2_i[XLEN-1];
    a_mag        = a_neg ? -rs1_i : rs1_i;
    b_mag        = b_neg ? -rs2_i : rs2_i;
    div_zero     = (sel_i == SEL_DIV) && (rs2_i == '0);
    div_ovf      = (sel_i == SEL_DIV) && rs1_is_signed(sel_i, op_i) &&
                   (rs1_i == MIN_INT) && (rs2_i == ALL_ONES);
    special      = div_zero || div_ovf;
    special_word = div_zero ? {rs1_i, ALL_ONES} : {{XLEN{1'b0}}, MIN_INT};
  end

  // Sign correction of the unsigned magnitude result.
  always_comb begin
    prod_abs = {acc, opnd};
    quot_fix = neg_main_q ? -opnd : opnd;
    rem_fix  = neg_rem_q ? -acc : acc;
    if (sel_q == SEL_DIV) fix_word = {rem_fix, quot_fix};
    else                  fix_word = neg_main_q ? -prod_abs : prod_abs;
  end

  // A completion is either a one-cycle bypass from IDLE or the FIX step.
  always_comb begin
    accept      = (state == ST_IDLE) && start_i && !flush_i;
    load_result = !flush_i && (((state == ST_IDLE) && start_i && (special || hit)) ||
                               (state == ST_FIX));
    done_word   = (state == ST_FIX) ? fix_word : (special ? special_word : hit_word);
    done_sel    = (state == ST_FIX) ? sel_q : sel_i;
    done_op     = (state == ST_FIX) ? op_q  : op_i;
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic              c_valid, c_sel;
  logic [1:0]        c_op;
  logic [XLEN-1:0]   c_rs1, c_rs2, rs1_q, rs2_q;
  logic [2*XLEN-1:0] c_word;

  // Any cached multiply serves MUL (low word is sign-independent); divides
  // share an entry when signedness matches since {rem, quot} is stored.
  always_comb begin
    hit      = c_valid && (c_sel == sel_i) && (c_rs1 == rs1_i) && (c_rs2 == rs2_i) &&
               ((sel_i == SEL_DIV) ? (c_op[0] == op_i[0])
                                   : ((op_i == OP_MUL) || (op_i == c_op)));
    hit_word = c_word;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      c_valid <= 1'b0;
      c_sel   <= 1'b0;
      c_op    <= '0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_word  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      if (accept) begin
        rs1_q <= rs1_i;
        rs2_q <= rs2_i;
      end
      if (load_result) begin
        c_valid <= 1'b1;
        c_sel   <= done_sel;
        c_op    <= done_op;
        c_rs1   <= (state == ST_FIX) ? rs1_q : rs1_i;
        c_rs2   <= (state == ST_FIX) ? rs2_q : rs2_i;
        c_word  <= done_word;
      end
    end
  end
`else
  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
  end
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Flush overrides every transition, including a start seen in IDLE.
  always_comb begin
    state_nxt = state;
    stall_o   = start_i && (state != ST_DONE);
    done_o    = (state == ST_DONE);
    case (state)
      ST_IDLE: if (start_i) state_nxt = (special || hit) ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush_i) state_nxt = ST_IDLE;
  end

  // Multiply keeps the multiplier in opnd; divide keeps the dividend there.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      b_reg      <= '0;
      sel_q      <= 1'b0;
      op_q       <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        cnt        <= '0;
        acc        <= '0;
        opnd       <= (sel_i == SEL_DIV) ? a_mag : b_mag;
        b_reg      <= (sel_i == SEL_DIV) ? b_mag : a_mag;
        sel_q      <= sel_i;
        op_q       <= op_i;
        neg_main_q <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
      end else if (state == ST_CALC) begin
        acc  <= acc_step;
        opnd <= opnd_step;
        cnt  <= cnt + 1'b1;
      end
      if (load_result) result_q <= pick_word(done_sel, done_op, done_word);
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: a table of directed vectors,
// hand-written multi-cycle sequences (back-to-back, flush, start drop,
// async reset) and a few random operations checked against a reference
// model. Builds with or without MULDIV_RESULT_CACHE_EN.
module tb_muldiv_sequencer;

  localparam int XLEN     = 32;
  localparam int BASE_LAT = XLEN + 2;
  localparam int BUDGET   = 100;
`ifdef MULDIV_RESULT_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk_i   = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic        sel_i   = 1'b0;
  logic [1:0]  op_i    = 2'b00;
  logic [31:0] rs1_i   = '0;
  logic [31:0] rs2_i   = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .sel_i    (sel_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] result;
    int          lat;
    int          extra;
    bit          chk_stall;
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[16];

  int n_pass  = 0;
  int n_total = 0;

  bit          c_valid = 1'b0;
  logic        c_sel   = 1'b0;
  logic [1:0]  c_op    = 2'b00;
  logic [31:0] c_a     = '0;
  logic [31:0] c_b     = '0;
  logic [31:0] last_result = '0;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic sel, input logic [1:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] pu;
    int          ia, ib;
    logic [31:0] q, r;
    ia = a;
    ib = b;
    if (!sel) begin
      sa = ((op == 2'b01) || (op == 2'b10)) ? longint'(ia) : longint'({32'h0, a});
      sb = (op == 2'b01) ? longint'(ib) : longint'({32'h0, b});
      p  = sa * sb;
      pu = p;
      return (op == 2'b00) ? pu[31:0] : pu[63:32];
    end
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      q = a;
      r = 32'h0;
    end else if (!op[0]) begin
      q = ia / ib;
      r = ia % ib;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int exp_latency(input logic sel, input logic [1:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
    bit special, hit;
    special = sel && ((b == 32'h0) || (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    hit     = c_valid && (c_sel == sel) && (c_a == a) && (c_b == b) &&
              (sel ? (c_op[0] == op[0]) : ((op == 2'b00) || (op == c_op)));
    if (special) return 1;
    if (CACHE_ON && hit) return 1;
    return BASE_LAT;
  endfunction

  // Drives one operation and records what it must produce. Called just
  // after a rising edge; the next edge is cycle 0 of the operation.
  task automatic apply_stimulus(input string name, input logic sel, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int extra, input bit chk_stall);
    exp_t e;
    start_i     = 1'b1;
    sel_i       = sel;
    op_i        = op;
    rs1_i       = a;
    rs2_i       = b;
    e.result    = exp;
    e.lat       = exp_latency(sel, op, a, b);
    e.extra     = extra;
    e.chk_stall = chk_stall;
    e.name      = name;
    sb_q.push_back(e);
    c_valid = 1'b1;
    c_sel   = sel;
    c_op    = op;
    c_a     = a;
    c_b     = b;
  endtask

  task automatic await_done(input int drop_at);
    exp_t e;
    int   cyc;
    int   stall_cnt;
    #1;
    stall_cnt = stall_o ? 1 : 0;
    cyc = 0;
    do begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (cyc == drop_at) start_i = 1'b0;
      if (!done_o && stall_o) stall_cnt++;
    end while (!done_o && (cyc < BUDGET));
    if (sb_q.size() == 0) begin
      n_total++;
      $display("[TB] FAIL scoreboard: done seen with no pending operation");
      return;
    end
    e = sb_q.pop_front();
    check_output({e.name, " latency"}, 32'(cyc), 32'(e.lat + e.extra));
    check_output({e.name, " result"}, result_o, e.result);
    if (e.chk_stall) begin
      check_output({e.name, " stall cycles"}, 32'(stall_cnt), 32'(e.lat));
      check_output({e.name, " stall at done"}, 32'(stall_o), 32'h0);
    end
    last_result = e.result;
  endtask

  task automatic run_op(input string name, input logic sel, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    apply_stimulus(name, sel, op, a, b, exp, 0, 1'b1);
    await_done(-1);
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_output({name, " done pulse"}, 32'(done_o), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{"MUL 7*-3",          1'b0, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{"MULHU -1*-1",       1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{"MULH -1*-1",        1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{"MULHSU -1*FFFFFFFF",1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{"DIV -7/2",          1'b1, 2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{"REM -7/2",          1'b1, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{"DIVU 100/0",        1'b1, 2'b01, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[7]  = '{"REM MIN/-1",        1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{"DIV MIN/-1",        1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{"REMU 100/0",        1'b1, 2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064};
    vecs[10] = '{"DIV 100/7",         1'b1, 2'b00, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E};
    vecs[11] = '{"REM 100/7",         1'b1, 2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002};
    vecs[12] = '{"DIV 7/-2",          1'b1, 2'b00, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[13] = '{"REM 7/-2",          1'b1, 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[14] = '{"MUL MIN*2",         1'b0, 2'b00, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000};
    vecs[15] = '{"MULHU MIN*4",       1'b0, 2'b11, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002};

    // Reset state, including stall_o following start_i while in reset.
    repeat (3) @(posedge clk_i);
    #1;
    check_output("reset done_o", 32'(done_o), 32'h0);
    check_output("reset result_o", result_o, 32'h0);
    check_output("reset stall_o idle", 32'(stall_o), 32'h0);
    start_i = 1'b1;
    #1;
    check_output("reset stall_o follows start", 32'(stall_o), 32'h1);
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].name, vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].result);

    // Back-to-back: the second op is presented during DONE and accepted in
    // the following IDLE cycle, one cycle later than a fresh start.
    apply_stimulus("b2b first MUL 3*5", 1'b0, 2'b00, 32'd3, 32'd5, 32'd15, 0, 1'b1);
    await_done(-1);
    apply_stimulus("b2b second MULHU", 1'b0, 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h1, 1, 1'b1);
    await_done(-1);
    start_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Flush mid-CALC: no completion, result held, engine usable afterwards.
    begin
      int dn;
      start_i = 1'b1;
      sel_i   = 1'b1;
      op_i    = 2'b01;
      rs1_i   = 32'd1000;
      rs2_i   = 32'd7;
      @(posedge clk_i);
      repeat (10) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      start_i = 1'b0;
      check_output("flush done_o", 32'(done_o), 32'h0);
      check_output("flush result held", result_o, last_result);
      dn = 0;
      repeat (40) begin
        @(posedge clk_i);
        #1;
        if (done_o) dn++;
      end
      check_output("flush no done pulses", 32'(dn), 32'h0);
    end
    run_op("DIVU 9/3 after flush", 1'b1, 2'b01, 32'd9, 32'd3, 32'd3);
    run_op("DIVU 1000/7 after flush", 1'b1, 2'b01, 32'd1000, 32'd7, 32'd142);

    // start_i dropping mid-CALC does not abort the operation.
    apply_stimulus("start drop MULHU", 1'b0, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678,
                   ref_result(1'b0, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678), 0, 1'b0);
    await_done(5);
    start_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Asynchronous reset in the middle of CALC.
    start_i = 1'b1;
    sel_i   = 1'b0;
    op_i    = 2'b00;
    rs1_i   = 32'd11;
    rs2_i   = 32'd13;
    @(posedge clk_i);
    repeat (10) @(posedge clk_i);
    #3;
    reset_i = 1'b0;
    #1;
    check_output("async reset done_o", 32'(done_o), 32'h0);
    check_output("async reset result_o", result_o, 32'h0);
    check_output("async reset stall_o", 32'(stall_o), 32'h1);
    start_i = 1'b0;
    #1;
    check_output("async reset stall_o drop", 32'(stall_o), 32'h0);
    c_valid     = 1'b0;
    last_result = '0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    run_op("MUL 11*13 after reset", 1'b0, 2'b00, 32'd11, 32'd13, 32'd143);

    // Random operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      logic        rsel;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rsel = 1'($urandom_range(0, 1));
      rop  = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op($sformatf("random %0d sel=%0d op=%0d", i, rsel, rop), rsel, rop, ra, rb,
             ref_result(rsel, rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
